// File: rtl/interrupt_acknowledge_pkg.sv
// Shared types and constants for the CPU-side 8259A interrupt-acknowledge initiator.
package interrupt_acknowledge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE_LOW,
        ST_PULSE_HIGH,
        ST_RECOVER
    } ack_state_t;

    localparam logic [7:0] CALL_OPCODE  = 8'hCD;
    localparam logic [1:0] PULSES_8086  = 2'd2;
    localparam logic [1:0] PULSES_MCS80 = 2'd3;

    // Index of the final INTA# pulse for the latched mode (1 = MCS-80).
    function automatic logic [1:0] last_pulse_index(input logic mcs80_mode);
        return mcs80_mode ? (PULSES_MCS80 - 2'd1) : (PULSES_8086 - 2'd1);
    endfunction

endpackage

// File: rtl/interrupt_acknowledge_initiator.sv
// Drives the INTA# pulse train toward an 8259A and assembles the returned
// vector (8086 mode) or CALL address (MCS-80 mode) for the processor model.
module interrupt_acknowledge_initiator
    import interrupt_acknowledge_pkg::*;
#(
    parameter int INTA_LOW_CYCLES  = 4,
    parameter int INTA_HIGH_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        interrupt,
    input  logic        interrupt_enable,
    input  logic        u8086_or_mcs80_config,
    input  logic [7:0]  data_bus_in,
    output logic        interrupt_acknowledge_n,
    output logic        acknowledge_busy,
    output logic        acknowledge_done,
    output logic [7:0]  interrupt_vector,
    output logic [15:0] call_address,
    output logic        call_opcode_error
);

    localparam logic [7:0] LOW_LOAD  = 8'(INTA_LOW_CYCLES - 1);
    localparam logic [7:0] HIGH_LOAD = 8'(INTA_HIGH_CYCLES - 1);

    ack_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        mode_q, mode_d;
    logic        req_q, req_d;
    logic        inta_n_q, inta_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  vector_q, vector_d;
    logic [15:0] call_q, call_d;
    logic        opcode_error_q, opcode_error_d;
    logic        pend_err_q, pend_err_d;

    // The qualified request is registered first, so the IDLE decision made on
    // one edge puts INTA# low on the following edge.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        mode_d         = mode_q;
        req_d          = interrupt & interrupt_enable;
        inta_n_d       = inta_n_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        vector_d       = vector_q;
        call_d         = call_q;
        opcode_error_d = opcode_error_q;
        pend_err_d     = pend_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_q) begin
                    state_d    = ST_PULSE_LOW;
                    mode_d     = u8086_or_mcs80_config;
                    idx_d      = 2'd0;
                    cnt_d      = LOW_LOAD;
                    inta_n_d   = 1'b0;
                    busy_d     = 1'b1;
                    pend_err_d = 1'b0;
                end
            end

            ST_PULSE_LOW: begin
                if (cnt_q == 8'd0) begin
                    if (mode_q) begin
                        unique case (idx_q)
                            2'd0:    pend_err_d    = (data_bus_in != CALL_OPCODE);
                            2'd1:    call_d[7:0]   = data_bus_in;
                            2'd2:    call_d[15:8]  = data_bus_in;
                            default: ;
                        endcase
                    end else if (idx_q == 2'd1) begin
                        vector_d = data_bus_in;
                    end
                    inta_n_d = 1'b1;
                    cnt_d    = HIGH_LOAD;
                    if (idx_q == last_pulse_index(mode_q)) begin
                        state_d        = ST_RECOVER;
                        done_d         = 1'b1;
                        opcode_error_d = mode_q & pend_err_q;
                    end else begin
                        state_d = ST_PULSE_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_PULSE_HIGH: begin
                if (cnt_q == 8'd0) begin
                    state_d  = ST_PULSE_LOW;
                    idx_d    = idx_q + 2'd1;
                    cnt_d    = LOW_LOAD;
                    inta_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_RECOVER: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                inta_n_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 8'd0;
            idx_q          <= 2'd0;
            mode_q         <= 1'b0;
            req_q          <= 1'b0;
            inta_n_q       <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            vector_q       <= 8'd0;
            call_q         <= 16'd0;
            opcode_error_q <= 1'b0;
            pend_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            mode_q         <= mode_d;
            req_q          <= req_d;
            inta_n_q       <= inta_n_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            vector_q       <= vector_d;
            call_q         <= call_d;
            opcode_error_q <= opcode_error_d;
            pend_err_q     <= pend_err_d;
        end
    end

    assign interrupt_acknowledge_n = inta_n_q;
    assign acknowledge_busy        = busy_q;
    assign acknowledge_done        = done_q;
    assign interrupt_vector        = vector_q;
    assign call_address            = call_q;
    assign call_opcode_error       = opcode_error_q;

endmodule
